// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage of the core.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed data priority with a starvation guard.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e        state_q, state_d;
  logic          sel_d_q, sel_d_d;     // current transaction belongs to the data side
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_d, grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;  // 0 = fetch preferred, 1 = data preferred

  always_comb begin
    grant_d = d_req && (!if_req || rr_q);
    grant_i = if_req && !grant_d;
    rr_d    = rr_q;
    if (state_q == IDLE && grant_d) rr_d = 1'b0;
    if (state_q == IDLE && grant_i) rr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
`else
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
  logic [3:0] run_q, run_d;

  // Consecutive data grants with fetch waiting; at the limit fetch is forced through.
  always_comb begin
    grant_d = d_req && (!if_req || run_q != RUN_MAX);
    grant_i = if_req && !grant_d;
    run_d   = run_q;
    if (state_q == IDLE) begin
      if (grant_d && if_req) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
      else if (grant_d || grant_i) run_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) run_q <= 4'd0;
    else       run_q <= run_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_d_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_d_q     <= sel_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d_d     = sel_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          sel_d_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          sel_d_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == BUSY_I)  if_rdata_d = mem_rdata;
          else if (!mem_we_q)     d_rdata_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_valid = (state_q == DONE) && !sel_d_q;
    d_valid  = (state_q == DONE) && sel_d_q;
    busy     = (state_q != IDLE);
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, delayed write, read, contention order,
// reset mid-transaction and spurious mem_ready.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;

  logic          clk = 1'b0, reset = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, d_valid, mem_req, mem_we, busy;

  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_order [10];
  logic got_order [$];

  initial begin
    // Reset state
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {if_valid, d_valid}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    tick();
    reset = 1'b0;

    // Single fetch, memory ready on first mem_req cycle
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 32'h40);
    chk("fetch_mem_we", mem_we, 0);
    mem_ready = 1'b1; mem_rdata = 32'h8C220004;
    tick();
    chk("fetch_if_valid", if_valid, 1);
    chk("fetch_d_valid", d_valid, 0);
    chk("fetch_if_rdata", if_rdata, 32'h8C220004);
    chk("fetch_mem_req_drop", mem_req, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("fetch_busy_idle", busy, 0);
    chk("fetch_valid_pulse", if_valid, 0);

    // Data write with mem_ready delayed 3 cycles; requester input changes are ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    d_addr = 32'h5555; d_wdata = 32'h0; d_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_mem_req", mem_req, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 32'h100);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_no_valid", {if_valid, d_valid}, 0);
      if (i < 2) tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("wr_d_valid", d_valid, 1);
    chk("wr_if_valid", if_valid, 0);
    chk("wr_d_rdata_hold", d_rdata, 0);
    chk("wr_mem_we_drop", mem_we, 0);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("wr_d_valid_pulse", d_valid, 0);

    // Data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 32'h200);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("rd_d_valid", d_valid, 1);
    chk("rd_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("rd_if_rdata_hold", if_rdata, 32'h8C220004);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Contention: both held high, memory always ready
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("excl_valid", if_valid & d_valid, 0);
      if (mem_req) got_order.push_back(mem_addr == 32'h2000);
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    chk("cont_n_grants_ge10", got_order.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      if (i < got_order.size()) chk($sformatf("cont_grant%0d_is_data", i), got_order[i], exp_order[i]);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    chk("cont_idle", busy, 0);

    // Reset mid-transaction in BUSY_D
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h77;
    tick();
    chk("rmid_busy_d", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("rmid_mem_req_drop", mem_req, 0);
    chk("rmid_busy", busy, 0);
    d_req = 1'b0;
    tick();
    chk("rmid_no_d_valid", d_valid, 0);
    reset = 1'b0;
    tick();
    chk("rmid_no_d_valid2", d_valid, 0);
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    chk("rmid_fetch_req", mem_req, 1);
    chk("rmid_fetch_addr", mem_addr, 32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h11;
    tick();
    chk("rmid_fetch_valid", if_valid, 1);
    chk("rmid_fetch_rdata", if_rdata, 32'h11);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Spurious mem_ready in IDLE: nothing may change
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_valids", {if_valid, d_valid}, 0);
      chk("spur_busy", busy, 0);
    end
    chk("spur_if_rdata", if_rdata, 32'h11);
    chk("spur_d_rdata", d_rdata, 0);
    mem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected end before 50000");
    $fatal(1);
  end
endmodule
